// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared divider state encoding, width and HI/LO write-enable encoding
package div_unit_pkg;

   localparam int DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // HI/LO write enables shared with the decoder: bit0 writes LO, bit1 writes HI
   localparam logic [1:0] HILO_LO   = 2'b01;
   localparam logic [1:0] HILO_HI   = 2'b10;
   localparam logic [1:0] HILO_BOTH = HILO_HI | HILO_LO;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           borrow;

   // rem < div on entry, so the shifted value is below 2*div and diff[WIDTH] is exactly the borrow
   always_comb begin
      shifted = {rem_i, quo_i[WIDTH-1]};
      diff    = shifted - {1'b0, div_i};
      borrow  = diff[WIDTH];
      rem_o   = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_o   = {quo_i[WIDTH-2:0], ~borrow};
   end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 DIV/DIVU unit with pipeline stall and HI/LO result
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic             cancel_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             stall_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             qsign_q, qsign_d, rsign_q, rsign_d;
   logic [WIDTH-1:0] step_rem, step_quo;
   logic             a_neg, b_neg;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .div_i (div_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   assign a_neg = signed_i & a_i[WIDTH-1];
   assign b_neg = signed_i & b_i[WIDTH-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      qsign_d = qsign_q;
      rsign_d = rsign_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      stall_o = 1'b0;
      valid_o = 1'b0;
      unique case (state_q)
         DIV_IDLE: begin
            if (start_i && !cancel_i && !rst) begin
               stall_o = 1'b1;
               rem_d   = '0;
               quo_d   = a_neg ? -a_i : a_i;
               div_d   = b_neg ? -b_i : b_i;
               qsign_d = a_neg ^ b_neg;
               rsign_d = a_neg;
               cnt_d   = '0;
               if (b_i == '0) begin
                  lo_d    = '1;
                  hi_d    = a_i;
                  state_d = DIV_DONE;
               end else begin
                  state_d = DIV_CALC;
               end
            end
         end
         DIV_CALC: begin
            if (cancel_i) begin
               state_d = DIV_IDLE;
            end else begin
               stall_o = ~rst;
               rem_d   = step_rem;
               quo_d   = step_quo;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  lo_d    = qsign_q ? -step_quo : step_quo;
                  hi_d    = rsign_q ? -step_rem : step_rem;
                  state_d = DIV_DONE;
               end
            end
         end
         DIV_DONE: begin
            valid_o = ~cancel_i & ~rst;
            state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic        signed_i = 1'b0;
   logic        cancel_i = 1'b0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        stall_o, valid_o;
   logic [31:0] hi_o, lo_o;

   int vec = 0;
   int miss = 0;
   logic [31:0] prev_lo, prev_hi;

   localparam int NDIV = 6;
   localparam logic        DV_S  [NDIV] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam logic [31:0] DV_A  [NDIV] = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
   localparam logic [31:0] DV_B  [NDIV] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'h10, 32'hFFFFFFFF, 32'h1234};
   localparam logic [31:0] DV_LO [NDIV] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0FFFFFFF, 32'h80000000, 32'h00010004};
   localparam logic [31:0] DV_HI [NDIV] = '{32'd1, 32'hFFFFFFFF, 32'd1, 32'hF, 32'h0, 32'h00000DA8};

   div_unit dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .signed_i (signed_i),
      .cancel_i (cancel_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .stall_o  (stall_o),
      .valid_o  (valid_o),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

   always #5 clk = ~clk;

   // Issues one op at the current negedge (cycle 0), holds start until valid_o, samples the result
   task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stalls, output logic stall_v,
                        output logic [31:0] lo, output logic [31:0] hi, output logic valid_after);
      signed_i = sgn; a_i = a; b_i = b; start_i = 1'b1;
      #1;
      lat = -1; stalls = 0; stall_v = 1'b1; lo = 'x; hi = 'x;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         if (valid_o === 1'b1) begin
            lat = k; stall_v = stall_o; lo = lo_o; hi = hi_o;
            break;
         end
         if (stall_o === 1'b1) stalls++;
      end
      start_i = 1'b0;
      @(negedge clk);
      valid_after = valid_o;
   endtask

   task automatic test_reset;
      @(negedge clk);
      vec++; if (stall_o !== 1'b0) begin miss++; $display("FAIL reset stall: got %b want 0", stall_o); end
      vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL reset valid: got %b want 0", valid_o); end
      vec++; if (lo_o !== 32'h0) begin miss++; $display("FAIL reset lo: got %h want 0", lo_o); end
      vec++; if (hi_o !== 32'h0) begin miss++; $display("FAIL reset hi: got %h want 0", hi_o); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_divide;
      int lat, stalls;
      logic sv, va;
      logic [31:0] lo, hi;
      for (int i = 0; i < NDIV; i++) begin
         do_op(DV_S[i], DV_A[i], DV_B[i], lat, stalls, sv, lo, hi, va);
         vec++; if (lat != 33) begin miss++; $display("FAIL div%0d latency: got %0d want 33", i, lat); end
         vec++; if (stalls != 33) begin miss++; $display("FAIL div%0d stall cycles: got %0d want 33", i, stalls); end
         vec++; if (sv !== 1'b0) begin miss++; $display("FAIL div%0d stall at valid: got %b want 0", i, sv); end
         vec++; if (lo !== DV_LO[i]) begin miss++; $display("FAIL div%0d lo: got %h want %h", i, lo, DV_LO[i]); end
         vec++; if (hi !== DV_HI[i]) begin miss++; $display("FAIL div%0d hi: got %h want %h", i, hi, DV_HI[i]); end
         vec++; if (va !== 1'b0) begin miss++; $display("FAIL div%0d valid width: got %b want 0", i, va); end
         vec++; if (lo_o !== DV_LO[i]) begin miss++; $display("FAIL div%0d lo hold: got %h want %h", i, lo_o, DV_LO[i]); end
      end
   endtask

   task automatic test_div_zero;
      int lat, stalls;
      logic sv, va;
      logic [31:0] lo, hi;
      logic [31:0] dividend [2];
      dividend[0] = 32'd5;
      dividend[1] = 32'hFFFFFFFB;
      for (int i = 0; i < 2; i++) begin
         do_op(i[0], dividend[i], 32'h0, lat, stalls, sv, lo, hi, va);
         vec++; if (lat != 1) begin miss++; $display("FAIL dz%0d latency: got %0d want 1", i, lat); end
         vec++; if (stalls != 1) begin miss++; $display("FAIL dz%0d stall cycles: got %0d want 1", i, stalls); end
         vec++; if (lo !== 32'hFFFFFFFF) begin miss++; $display("FAIL dz%0d lo: got %h want ffffffff", i, lo); end
         vec++; if (hi !== dividend[i]) begin miss++; $display("FAIL dz%0d hi: got %h want %h", i, hi, dividend[i]); end
         vec++; if (va !== 1'b0) begin miss++; $display("FAIL dz%0d valid width: got %b want 0", i, va); end
      end
      prev_lo = 32'hFFFFFFFF;
      prev_hi = 32'hFFFFFFFB;
   endtask

   task automatic test_cancel;
      int lat, stalls;
      logic sv, va;
      logic [31:0] lo, hi;
      signed_i = 1'b0; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
      #1;
      repeat (10) @(negedge clk);
      cancel_i = 1'b1;
      #1;
      vec++; if (stall_o !== 1'b0) begin miss++; $display("FAIL cancel stall: got %b want 0", stall_o); end
      vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL cancel valid: got %b want 0", valid_o); end
      @(negedge clk);
      cancel_i = 1'b0;
      vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL cancel next valid: got %b want 0", valid_o); end
      vec++; if (lo_o !== prev_lo) begin miss++; $display("FAIL cancel lo kept: got %h want %h", lo_o, prev_lo); end
      vec++; if (hi_o !== prev_hi) begin miss++; $display("FAIL cancel hi kept: got %h want %h", hi_o, prev_hi); end
      do_op(1'b1, 32'hFFFFFF9C, 32'd7, lat, stalls, sv, lo, hi, va);
      vec++; if (lat != 33) begin miss++; $display("FAIL after cancel latency: got %0d want 33", lat); end
      vec++; if (lo !== 32'hFFFFFFF2) begin miss++; $display("FAIL after cancel lo: got %h want fffffff2", lo); end
      vec++; if (hi !== 32'hFFFFFFFE) begin miss++; $display("FAIL after cancel hi: got %h want fffffffe", hi); end
   endtask

   task automatic test_reset_mid;
      int lat, stalls;
      logic sv, va;
      logic [31:0] lo, hi;
      signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
      #1;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vec++; if (stall_o !== 1'b0) begin miss++; $display("FAIL midrst stall: got %b want 0", stall_o); end
      vec++; if (lo_o !== 32'h0) begin miss++; $display("FAIL midrst lo: got %h want 0", lo_o); end
      vec++; if (hi_o !== 32'h0) begin miss++; $display("FAIL midrst hi: got %h want 0", hi_o); end
      @(negedge clk);
      vec++; if (valid_o !== 1'b0) begin miss++; $display("FAIL midrst valid: got %b want 0", valid_o); end
      rst = 1'b0;
      do_op(1'b0, 32'd1000, 32'd3, lat, stalls, sv, lo, hi, va);
      vec++; if (lat != 33) begin miss++; $display("FAIL postrst latency: got %0d want 33", lat); end
      vec++; if (stalls != 33) begin miss++; $display("FAIL postrst stall cycles: got %0d want 33", stalls); end
      vec++; if (lo !== 32'd333) begin miss++; $display("FAIL postrst lo: got %h want 0000014d", lo); end
      vec++; if (hi !== 32'd1) begin miss++; $display("FAIL postrst hi: got %h want 1", hi); end
   endtask

   initial begin
      test_reset();
      test_divide();
      test_div_zero();
      test_cancel();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
